// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the spiking-network readout blocks.
package snn_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StScan,
    StOut
  } win_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_count_bank.sv
// Bank of saturating per-node spike counters with a single indexed read port.
module spike_count_bank #(
  parameter int unsigned NUM_NODES = 10,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [NUM_NODES-1:0] spikes_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [CNT_W-1:0]     rd_count_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [NUM_NODES];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc_i) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        if (spikes_i[i] && (cnt_q[i] != CntMax)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Explicit compare-mux keeps out-of-range indices reading zero.
  always_comb begin
    rd_count_o = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_count_o = cnt_q[i];
      end
    end
  end

endmodule

// File: rtl/inference_window_ctrl.sv
// Windowed spike-count classifier: clear, count WINDOW_LEN ticks, argmax scan,
// then hold the winner on a valid/ready handshake.
module inference_window_ctrl
  import snn_pkg::*;
#(
  parameter int unsigned NUM_NODES  = 10,
  parameter int unsigned WINDOW_LEN = 100,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned IdxW      = idx_width(NUM_NODES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 tick_i,
  input  logic [NUM_NODES-1:0] nodes_i,
  output logic                 clear_o,
  output logic                 busy_o,
  output logic                 winner_valid_o,
  input  logic                 winner_ready_i,
  output logic [IdxW-1:0]      winner_idx_o,
  output logic [CNT_W-1:0]     winner_count_o,
  output logic                 tie_o
);

  localparam int unsigned TickW = idx_width(WINDOW_LEN);
  localparam logic [TickW-1:0] LastTick = TickW'(WINDOW_LEN - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_NODES - 1);

  win_state_e       state_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [IdxW-1:0]  scan_k_q;
  logic [CNT_W-1:0] best_q, best_d;
  logic [IdxW-1:0]  best_idx_q, best_idx_d;
  logic             tie_scan_q, tie_scan_d;
  logic             clear_q, busy_q, valid_q, tie_q;
  logic [IdxW-1:0]  idx_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] rd_count;

  spike_count_bank #(
    .NUM_NODES (NUM_NODES),
    .CNT_W     (CNT_W),
    .IDX_W     (IdxW)
  ) u_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (state_q == StClear),
    .inc_i      ((state_q == StRun) && tick_i),
    .spikes_i   (nodes_i),
    .rd_idx_i   (scan_k_q),
    .rd_count_o (rd_count)
  );

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    tie_scan_d = tie_scan_q;
    if (scan_k_q == '0) begin
      best_d     = rd_count;
      best_idx_d = '0;
      tie_scan_d = 1'b0;
    end else if (rd_count > best_q) begin
      best_d     = rd_count;
      best_idx_d = scan_k_q;
      tie_scan_d = 1'b0;
    end else if (rd_count == best_q) begin
      tie_scan_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      scan_k_q   <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      tie_scan_q <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      tie_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StClear;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          state_q    <= StRun;
          clear_q    <= 1'b0;
          tick_cnt_q <= '0;
          scan_k_q   <= '0;
          best_q     <= '0;
          best_idx_q <= '0;
          tie_scan_q <= 1'b0;
        end
        StRun: begin
          if (tick_i) begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
            if (tick_cnt_q == LastTick) begin
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          tie_scan_q <= tie_scan_d;
          scan_k_q   <= scan_k_q + IdxW'(1);
          if (scan_k_q == LastIdx) begin
            state_q <= StOut;
            valid_q <= 1'b1;
            idx_q   <= best_idx_d;
            count_q <= best_d;
            tie_q   <= tie_scan_d;
          end
        end
        StOut: begin
          if (winner_ready_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clear_o        = clear_q;
  assign busy_o         = busy_q;
  assign winner_valid_o = valid_q;
  assign winner_idx_o   = idx_q;
  assign winner_count_o = count_q;
  assign tie_o          = tie_q;

endmodule

// File: tb/tb_inference_window_ctrl.sv
// Scoreboard bench: two instances (16-bit and 2-bit counters) share stimulus.
module tb_inference_window_ctrl;

  localparam int NN = 4;
  localparam int WL = 5;

  logic clk = 1'b0;
  logic rst, start, tick, ready;
  logic [NN-1:0] nodes;

  logic        clear_a, busy_a, valid_a, tie_a;
  logic [1:0]  idx_a;
  logic [15:0] cnt_a;
  logic        clear_b, busy_b, valid_b, tie_b;
  logic [1:0]  idx_b;
  logic [1:0]  cnt_b;

  typedef struct packed {
    int   idx;
    int   cnt;
    logic tie;
  } res_t;

  res_t  qa[$];
  res_t  qb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string cur_test = "reset";

  inference_window_ctrl #(.NUM_NODES(NN), .WINDOW_LEN(WL), .CNT_W(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick), .nodes_i(nodes),
    .clear_o(clear_a), .busy_o(busy_a), .winner_valid_o(valid_a),
    .winner_ready_i(ready), .winner_idx_o(idx_a), .winner_count_o(cnt_a), .tie_o(tie_a)
  );

  inference_window_ctrl #(.NUM_NODES(NN), .WINDOW_LEN(WL), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick), .nodes_i(nodes),
    .clear_o(clear_b), .busy_o(busy_b), .winner_valid_o(valid_b),
    .winner_ready_i(ready), .winner_idx_o(idx_b), .winner_count_o(cnt_b), .tie_o(tie_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0d, expected %0d", cur_test, name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL [%s] %s", cur_test, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors pop one expectation per accepted result.
  always @(negedge clk) begin
    if (!rst && valid_a && ready) begin
      if (qa.size() == 0) fail_now("a: result with no expectation");
      else begin
        res_t e;
        e = qa.pop_front();
        check("a winner_idx", int'(idx_a), e.idx);
        check("a winner_count", int'(cnt_a), e.cnt);
        check("a tie", int'(tie_a), int'(e.tie));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_b && ready) begin
      if (qb.size() == 0) fail_now("b: result with no expectation");
      else begin
        res_t e;
        e = qb.pop_front();
        check("b winner_idx", int'(idx_b), e.idx);
        check("b winner_count", int'(cnt_b), e.cnt);
        check("b tie", int'(tie_b), int'(e.tie));
      end
    end
  end

  // pat lists the five tick vectors, first tick in the top nibble.
  task automatic run_inf(input string name, input logic [19:0] pat, input int gap,
                         input logic [3:0] idle, input res_t ea, input res_t eb,
                         input bit hold);
    int t_start, t_last, guard;
    cur_test = name;
    qa.push_back(ea);
    qb.push_back(eb);
    start = 1'b1;
    step();
    t_start = cyc;
    start = 1'b0;
    check("clear_o in CLEAR", int'(clear_a), 1);
    check("busy_o in CLEAR", int'(busy_a), 1);
    step();
    check("clear_o one-cycle", int'(clear_a), 0);
    for (int j = 0; j < WL; j++) begin
      for (int g = 0; g < gap; g++) begin
        tick  = 1'b0;
        nodes = idle;
        step();
      end
      tick  = 1'b1;
      nodes = pat[19-4*j -: 4];
      step();
    end
    t_last = cyc;
    tick   = 1'b0;
    nodes  = idle;
    guard  = 0;
    while (!valid_a && guard < 40) begin
      step();
      guard++;
    end
    if (!valid_a) begin
      fail_now("timeout waiting for winner_valid_o");
    end else begin
      // Valid in cycle r+NN+1, i.e. seen right after edge r+NN.
      check("valid edges after final tick", cyc - t_last, NN);
      if (gap == 0) check("valid edges after start", cyc - t_start, WL + NN + 1);
      check("b valid with a", int'(valid_b), 1);
    end
    if (!hold) begin
      step();
      check("valid dropped after handshake", int'(valid_a), 0);
      check("busy dropped after handshake", int'(busy_a), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; ready = 1'b1; nodes = '0;
    step(); step(); step();
    check("reset clear_o", int'(clear_a), 0);
    check("reset busy_o", int'(busy_a), 0);
    check("reset valid", int'(valid_a), 0);
    check("reset idx", int'(idx_a), 0);
    check("reset count", int'(cnt_a), 0);
    check("reset tie", int'(tie_a), 0);
    rst = 1'b0;
    step();

    run_inf("single_winner", {4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100}, 0, 4'b0000,
            '{idx: 2, cnt: 5, tie: 1'b0}, '{idx: 2, cnt: 3, tie: 1'b0}, 1'b0);
    run_inf("tie_low_idx", {4'b1011, 4'b1011, 4'b1010, 4'b0000, 4'b0000}, 0, 4'b0000,
            '{idx: 1, cnt: 3, tie: 1'b1}, '{idx: 1, cnt: 3, tie: 1'b1}, 1'b0);
    run_inf("saturate", {4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001}, 0, 4'b0000,
            '{idx: 0, cnt: 5, tie: 1'b0}, '{idx: 0, cnt: 3, tie: 1'b0}, 1'b0);
    run_inf("sparse_ticks", {4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010}, 2, 4'b1111,
            '{idx: 1, cnt: 5, tie: 1'b0}, '{idx: 1, cnt: 3, tie: 1'b0}, 1'b0);
    run_inf("all_silent", {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000}, 0, 4'b0000,
            '{idx: 0, cnt: 0, tie: 1'b1}, '{idx: 0, cnt: 0, tie: 1'b1}, 1'b0);

    ready = 1'b0;
    run_inf("stall", {4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b0000}, 0, 4'b0000,
            '{idx: 3, cnt: 3, tie: 1'b0}, '{idx: 3, cnt: 3, tie: 1'b0}, 1'b1);
    for (int i = 0; i < 10; i++) begin
      start = ~start;
      step();
      check("stall valid held", int'(valid_a), 1);
      check("stall idx held", int'(idx_a), 3);
      check("stall count held", int'(cnt_a), 3);
      check("stall no clear", int'(clear_a), 0);
    end
    // Start high on the handshake edge must be ignored.
    start = 1'b1;
    ready = 1'b1;
    step();
    check("idle after handshake busy", int'(busy_a), 0);
    check("idle after handshake valid", int'(valid_a), 0);
    check("start ignored in OUT", int'(clear_a), 0);
    check("idx held in IDLE", int'(idx_a), 3);
    step();
    check("restart clear pulse", int'(clear_a), 1);
    start = 1'b0;

    cur_test = "reset_in_run";
    step();
    tick  = 1'b1;
    nodes = 4'b0001;
    step();
    step();
    tick = 1'b0;
    rst  = 1'b1;
    step();
    check("rst busy", int'(busy_a), 0);
    check("rst clear", int'(clear_a), 0);
    check("rst valid", int'(valid_a), 0);
    check("rst idx", int'(idx_a), 0);
    check("rst count", int'(cnt_a), 0);
    check("rst tie", int'(tie_a), 0);
    check("rst b count", int'(cnt_b), 0);
    rst   = 1'b0;
    nodes = 4'b0000;
    step();
    run_inf("after_reset", {4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b0000}, 0, 4'b0000,
            '{idx: 3, cnt: 2, tie: 1'b0}, '{idx: 3, cnt: 2, tie: 1'b0}, 1'b0);

    step();
    cur_test = "end";
    check("a expectations consumed", qa.size(), 0);
    check("b expectations consumed", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inference_window_ctrl.md
# inference_window_ctrl

Sequences one classification inference over a fixed window of network timesteps for an output layer of NUM_NODES spiking neurons. On start it clears the network, then accumulates per-node spike counts over WINDOW_LEN timesteps. It then runs a sequential argmax scan and presents the winning node index and count through a valid/ready handshake. It sits between the output spiking layer and the host/readout logic, replacing free-running running-winner tracking with windowed, deterministic classification.

## Interface
Parameters:
- NUM_NODES, 10: number of output neurons (≥1).
- WINDOW_LEN, 100: timesteps per inference (≥1).
- CNT_W, 16: spike counter width (≥1).

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  begin an inference; honoured only in IDLE.
- tick_i  input  1  one network timestep completed; nodes_i valid this cycle.
- nodes_i  input  NUM_NODES  spike vector for the current timestep.
- clear_o  output  1  one-cycle pulse; clears network membrane state.
- busy_o  output  1  high in every state except IDLE.
- winner_valid_o  output  1  result available.
- winner_ready_i  input  1  consumer accepts result.
- winner_idx_o  output  $clog2(NUM_NODES) (min 1)  winning node index.
- winner_count_o  output  CNT_W  spike count of winner.
- tie_o  output  1  another node has a count equal to the winner's.

## Operation
- FSM states: IDLE, CLEAR, RUN, SCAN, OUT.
- IDLE: start_i=1 → CLEAR. Otherwise stay.
- CLEAR (exactly 1 cycle): clear_o=1; all counters, tick counter, scan registers zeroed at end of cycle → RUN.
- RUN: on each cycle with tick_i=1, counter[i] += nodes_i[i] for every i. Counters are saturating at 2^CNT_W−1. Tick counter increments. The tick that brings the tick count to WINDOW_LEN is counted and moves the FSM → SCAN. nodes_i is ignored when tick_i=0 and outside RUN.
- SCAN: one node per cycle, index k = 0..NUM_NODES−1.
  - k=0 loads best = counter[0], best_idx = 0, tie = 0.
  - For k>0: if counter[k] > best, update best/best_idx and clear tie. If counter[k] == best, set tie. Strict compare, so lowest index wins ties.
  - After k = NUM_NODES−1 → OUT.
- OUT: winner_valid_o=1. winner_idx_o, winner_count_o and tie_o are registered and stable until handshake. On winner_valid_o & winner_ready_i → IDLE.
- All-silent window: idx 0, count 0, tie_o=1 if NUM_NODES>1.
- start_i outside IDLE is ignored, including in the OUT handshake cycle. A start asserted in the cycle the FSM returns to IDLE is honoured.
- tick_i in CLEAR, SCAN or OUT is ignored; no backpressure to the network.

## Timing
- Reset: state IDLE; clear_o, busy_o, winner_valid_o, tie_o = 0; winner_idx_o, winner_count_o = 0; counters = 0.
- Reset in any state aborts immediately and yields the reset values next cycle. No partial result is emitted.
- start_i high at edge t → clear_o and busy_o high in cycle t+1. RUN begins at cycle t+2.
- Final tick at edge r → SCAN cycles r+1 .. r+NUM_NODES. winner_valid_o high from cycle r+NUM_NODES+1.
- Minimum start-to-valid latency is WINDOW_LEN + NUM_NODES + 2 cycles, reached with tick_i held high.
- Handshake completes on the edge where both valid and ready are high. busy_o and winner_valid_o drop the next cycle. Outputs hold their last values while in IDLE.

## Structure
- Shared package snn_pkg holds:
  - the FSM state enum (win_state_e),
  - the localparam-derived index width function/constant used for NUM_NODES index sizing.
- Sub-module spike_count_bank holds NUM_NODES saturating CNT_W counters.
  - Inputs: clr, inc enable (RUN & tick_i), spike vector, read index.
  - Output: the selected counter value.
  - The controller holds the FSM, tick counter, scan registers and output registers.

## Test plan
- NUM_NODES=4, WINDOW_LEN=5, tick_i always 1, node 2 spikes every tick, others never → idx=2, count=5, tie_o=0; valid rises exactly 11 cycles after the start edge.
- Nodes 1 and 3 each spike 3 times, node 0 twice → idx=1, count=3, tie_o=1.
- CNT_W=2, node 0 spikes 5 of 5 ticks → count saturates at 3, idx=0.
- tick_i pulsed every 3rd cycle, and nodes_i is active on non-tick cycles → those spikes are not counted; the window ends after the 5th tick.
- Hold winner_ready_i=0 for 10 cycles in OUT while toggling start_i → outputs stable, no restart. Set ready=1 → IDLE next cycle; a following start produces a clear_o pulse.
- Assert rst_i during RUN after 2 ticks → all outputs 0 next cycle. A fresh start counts from zero, and the result reflects only the new window.
